// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data access path:
// transfer sizes, controller states and store lane replication.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } dmem_state_t;

    function automatic logic [31:0] store_replicate(
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{wdata[7:0]}};
            SZ_HALF: r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rdata_extend.sv
// Load data alignment: picks the addressed byte/half lane of the
// raw bus word and sign- or zero-extends it to 32 bits.
module rdata_extend
    import mem_pkg::*;
(
    input  logic        sign_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh = rdata_i >> {off_i, 3'b000};
        b  = sh[7:0];
        h  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_i & b[7]}}, b};
            SZ_HALF: data_o = {{16{sign_i & h[15]}}, h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: one load/store per instruction
// on the req/addr_ok/data_ok bus, with stall and flush-drain handling.
module dmem_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    input  logic        pipe_ready,
    output logic        mem_busy,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        addr_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    dmem_state_t state_q, state_d;

    logic        wr_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic [1:0]  size_n;
    logic        misalign;
    logic        accept;
    logic        capture;
    logic [31:0] ext;

    assign size_n = (mem_size == 2'b11) ? SZ_WORD : mem_size;

    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            (size_n == SZ_HALF): misalign = mem_addr[0];
            (size_n == SZ_WORD): misalign = |mem_addr[1:0];
            default:             misalign = 1'b0;
        endcase
    end

    assign accept  = (state_q == S_IDLE) & mem_req & ~misalign & ~flush;
    assign capture = (state_q == S_WAIT) & data_data_ok & ~flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_REQ;
            end
            S_REQ: begin
                if (data_addr_ok) state_d = flush ? S_DRAIN : S_WAIT;
                else if (flush)   state_d = S_IDLE;
            end
            S_WAIT: begin
                if (data_data_ok) state_d = flush ? S_IDLE : S_DONE;
                else if (flush)   state_d = S_DRAIN;
            end
            S_DONE: begin
                if (pipe_ready | flush) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (data_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    rdata_extend u_ext (
        .sign_i  (sign_q),
        .rdata_i (data_rdata),
        .size_i  (size_q),
        .off_i   (addr_q[1:0]),
        .data_o  (ext)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= mem_wr;
                sign_q  <= mem_sign;
                size_q  <= size_n;
                addr_q  <= mem_addr;
                wdata_q <= store_replicate(size_n, mem_wdata);
            end
            // stores complete with a zero result
            if (capture) rdata_q <= wr_q ? 32'h0 : ext;
        end
    end

    assign mem_busy   = accept | (state_q == S_REQ) | (state_q == S_WAIT)
                      | (state_q == S_DRAIN);
    assign mem_done   = (state_q == S_DONE);
    assign mem_rdata  = rdata_q;
    assign addr_err   = mem_req & misalign;
    assign data_req   = (state_q == S_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: random-latency bus slave, reference
// memory model, directed corner cases and randomized load/store mix.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_sign = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        flush = 1'b0;
    logic        pipe_ready = 1'b0;
    logic        mem_busy;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        addr_err;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;

    dmem_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_sign     (mem_sign),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .pipe_ready   (pipe_ready),
        .mem_busy     (mem_busy),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .addr_err     (addr_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] bmem [64];
    logic [31:0] rmem [64];
    logic [31:0] expq [$];

    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w,
        input logic [1:0] s, input logic sg, input logic [1:0] off);
        int nb;
        logic [31:0] m, v;
        nb = nbytes(s);
        if (nb == 4) return w;
        m = (nb == 1) ? 32'hFF : 32'hFFFF;
        v = (w >> (8 * off)) & m;
        if (sg && ((v & ((m + 1) >> 1)) != 0)) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [1:0] s,
                                              input logic [31:0] wd);
        int nb;
        nb = nbytes(s);
        if (nb == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // bus slave knobs and expectations set by the driver
    int          a_dly = 0;
    int          d_dly = 1;
    bit          frc = 1'b0;
    logic [31:0] frc_val = '0;
    logic        exp_wr = 1'b0;
    logic [1:0]  exp_size = 2'b00;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    int          last_dok_cyc = -10;

    bit          in_req = 1'b0;
    bit          pend = 1'b0;
    int          acnt = 0;
    int          dcnt = 0;
    logic [31:0] rd_word = '0;
    logic [31:0] snap_addr, snap_wdata;
    logic [1:0]  snap_size;
    logic        snap_wr;

    always @(negedge clk) begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!resetn) begin
            in_req = 1'b0;
            pend   = 1'b0;
        end else if (pend) begin
            if (dcnt == 0) begin
                data_data_ok = 1'b1;
                data_rdata   = rd_word;
                pend         = 1'b0;
                last_dok_cyc = cyc_n;
            end else begin
                dcnt--;
            end
        end else if (data_req) begin
            if (!in_req) begin
                in_req     = 1'b1;
                acnt       = a_dly;
                snap_addr  = data_addr;
                snap_wdata = data_wdata;
                snap_size  = data_size;
                snap_wr    = data_wr;
            end else begin
                chk("req_stable_addr", data_addr, snap_addr);
                chk("req_stable_wdata", data_wdata, snap_wdata);
                chk("req_stable_ctl", {29'b0, data_wr, data_size},
                    {29'b0, snap_wr, snap_size});
            end
            if (acnt == 0) begin
                data_addr_ok = 1'b1;
                in_req = 1'b0;
                pend   = 1'b1;
                dcnt   = d_dly - 1;
                chk("bus_addr", data_addr, exp_addr);
                chk("bus_ctl", {29'b0, data_wr, data_size},
                    {29'b0, exp_wr, exp_size});
                rd_word = frc ? frc_val : bmem[data_addr[7:2]];
                frc = 1'b0;
                if (data_wr) begin
                    chk("bus_wdata", data_wdata, exp_wdata);
                    for (int k = 0; k < nbytes(data_size); k++) begin
                        int ln;
                        ln = int'(data_addr[1:0]) + k;
                        bmem[data_addr[7:2]][8*ln +: 8] = data_wdata[8*ln +: 8];
                    end
                end
            end else begin
                acnt--;
            end
        end else begin
            in_req = 1'b0;
        end
    end

    // monitor: pops the scoreboard on every completed result
    bit          held = 1'b0;
    logic [31:0] held_val = '0;

    always @(negedge clk) begin
        #1;
        if (resetn) begin
            if (mem_done) begin
                chk("busy_in_done", {31'b0, mem_busy}, 32'd0);
                if (held) chk("rdata_hold", mem_rdata, held_val);
                if (pipe_ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        chk("rdata", mem_rdata, expq.pop_front());
                    end
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_val = mem_rdata;
                end
            end else if (held) begin
                chk("done_dropped", {31'b0, mem_done}, 32'd1);
                held = 1'b0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd, input bit push);
        logic [1:0] szn;
        szn = (sz == 2'b11) ? 2'b10 : sz;
        mem_req   = 1'b1;
        mem_wr    = wr;
        mem_size  = sz;
        mem_sign  = sg;
        mem_addr  = ad;
        mem_wdata = wd;
        exp_wr    = wr;
        exp_size  = szn;
        exp_addr  = ad;
        exp_wdata = ref_lanes(szn, wd);
        if (push) begin
            if (wr) begin
                expq.push_back(32'h0);
                for (int k = 0; k < nbytes(szn); k++) begin
                    int ln;
                    ln = int'(ad[1:0]) + k;
                    rmem[ad[7:2]][8*ln +: 8] = wd[8*k +: 8];
                end
            end else begin
                expq.push_back(ref_load(rmem[ad[7:2]], szn, sg, ad[1:0]));
            end
        end
    endtask

    task automatic wait_done(input int lat, input int pr);
        int c, hold, dcy;
        bit fin;
        c = 0; hold = pr; dcy = 0; fin = 1'b0;
        while (!fin && c < 200) begin
            @(negedge clk);
            c++;
            if (mem_done) begin
                if (dcy == 0 && lat >= 0) chk("latency", c, lat);
                dcy++;
                if (hold > 0) begin
                    pipe_ready = 1'b0;
                    hold--;
                end else begin
                    pipe_ready = 1'b1;
                    fin = 1'b1;
                end
            end else if (dcy == 0) begin
                chk("busy_pending", {31'b0, mem_busy}, 32'd1);
            end
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        else chk("done_cycles", dcy, pr + 1);
        @(negedge clk);
        pipe_ready = 1'b0;
        mem_req    = 1'b0;
    endtask

    task automatic op(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      input int a, input int d, input int pr);
        logic [1:0] szn;
        bit mis;
        szn = (sz == 2'b11) ? 2'b10 : sz;
        mis = (szn == 2'b01 && ad[0]) || (szn == 2'b10 && ad[1:0] != 2'b00);
        a_dly = a;
        d_dly = d;
        issue(wr, sz, sg, ad, wd, !mis);
        #1;
        if (mis) begin
            chk("addr_err", {31'b0, addr_err}, 32'd1);
            chk("mis_busy", {31'b0, mem_busy}, 32'd0);
            @(negedge clk);
            chk("mis_no_req", {31'b0, data_req}, 32'd0);
            chk("mis_no_done", {31'b0, mem_done}, 32'd0);
            mem_req = 1'b0;
        end else begin
            chk("ok_busy", {31'b0, mem_busy}, 32'd1);
            chk("ok_no_err", {31'b0, addr_err}, 32'd0);
            wait_done(2 + a + d, pr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, req_cyc;
        for (int i = 0; i < 64; i++) begin
            bmem[i] = $urandom;
            rmem[i] = bmem[i];
        end

        #12;
        chk("rst_req", {31'b0, data_req}, 32'd0);
        chk("rst_done", {31'b0, mem_done}, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // signed byte load at lane 3
        a_dly = 0; d_dly = 1;
        frc = 1'b1; frc_val = 32'h80FF_0000;
        issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0);
        expq.push_back(32'hFFFF_FF80);
        #1 chk("t1_busy", {31'b0, mem_busy}, 32'd1);
        wait_done(3, 0);

        // halfword store, addr_ok delayed two cycles
        op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234, 2, 1, 0);

        // misaligned word load
        op(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 0, 1, 0);

        // flush in WAIT, then drain while a new load waits
        a_dly = 0; d_dly = 3;
        frc = 1'b1; frc_val = 32'hDEAD_BEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        @(negedge clk);
        chk("fl_req", {31'b0, data_req}, 32'd1);
        @(negedge clk);
        chk("fl_wait_busy", {31'b0, mem_busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        a_dly = 0; d_dly = 1;
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1);
        #1;
        chk("drain_busy", {31'b0, mem_busy}, 32'd1);
        chk("drain_no_req", {31'b0, data_req}, 32'd0);
        k = 0;
        while (!data_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_cyc = cyc_n;
        if (k >= 20) chk("drain_req_timeout", 32'd0, 32'd1);
        chk("drain_order",
            {31'b0, (req_cyc > last_dok_cyc) && (req_cyc <= last_dok_cyc + 2)},
            32'd1);
        wait_done(-1, 0);

        // result held while downstream stalls
        op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, 1, 3);

        for (int n = 0; n < 150; n++) begin
            logic [1:0]  sz;
            logic [31:0] ad;
            sz = 2'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                else if (sz != 2'b00) ad[1:0] = 2'b00;
            end
            op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
               $urandom, $urandom_range(0, 2), $urandom_range(1, 3),
               $urandom_range(0, 2));
        end

        // reset in the middle of a request
        a_dly = 5; d_dly = 1;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        chk("rr_req", {31'b0, data_req}, 32'd1);
        #2;
        resetn  = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("rr_req0", {31'b0, data_req}, 32'd0);
        chk("rr_busy0", {31'b0, mem_busy}, 32'd0);
        chk("rr_done0", {31'b0, mem_done}, 32'd0);
        chk("rr_err0", {31'b0, addr_err}, 32'd0);
        chk("rr_rdata0", mem_rdata, 32'd0);
        chk("rr_addr0", data_addr, 32'd0);
        chk("rr_wdata0", data_wdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_idle_req", {31'b0, data_req}, 32'd0);
            chk("rr_idle_busy", {31'b0, mem_busy}, 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
